// File: rtl/gf180mcu_fd_sc_mcu7t5v0__arb4_rr.sv
// Four-way round-robin arbiter with owner hold timeout and a one-cycle bus turnaround.
// Every output is registered; a timeout forces release and raises a single-cycle TO pulse.
module gf180mcu_fd_sc_mcu7t5v0__arb4_rr #(
  parameter int TIMEOUT = 8
) (
`ifdef USE_POWER_PINS
  inout  wire        VDD,
  inout  wire        VSS,
`endif
  input  logic       CLK,
  input  logic       RN,
  input  logic [3:0] REQ,
  input  logic       DONE,
  output logic [3:0] GNT,
  output logic       BUSY,
  output logic       TO
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [1:0] ptr;
  logic [1:0] own;
  logic [7:0] cnt;

  logic [1:0] sel;
  logic       releaseReq;
  logic       timeoutHit;

  // The candidate is the first requester found scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  always_comb begin
    sel = ptr;
    for (int i = 3; i >= 0; i--) begin
      if (REQ[ptr + 2'(i)]) begin
        sel = ptr + 2'(i);
      end
    end
  end

  assign releaseReq = DONE || !REQ[own];
  assign timeoutHit = (cnt == CNT_LAST);

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state <= IDLE;
      ptr   <= 2'd0;
      own   <= 2'd0;
      cnt   <= 8'd0;
      GNT   <= 4'b0000;
      BUSY  <= 1'b0;
      TO    <= 1'b0;
    end else begin
      TO <= 1'b0;
      case (state)
        IDLE: begin
          if (REQ != 4'b0000) begin
            own   <= sel;
            GNT   <= 4'b0001 << sel;
            BUSY  <= 1'b1;
            cnt   <= 8'd0;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (cnt != 8'hFF) begin
            cnt <= cnt + 8'd1;
          end
          // A voluntary release wins over a coincident timeout, so TO stays low then.
          if (releaseReq || timeoutHit) begin
            GNT   <= 4'b0000;
            BUSY  <= 1'b0;
            ptr   <= own + 2'd1;
            TO    <= !releaseReq;
            state <= RELEASE;
          end
        end
        RELEASE: begin
          state <= IDLE;
        end
        default: begin
          GNT   <= 4'b0000;
          BUSY  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/gf180mcu_fd_sc_mcu7t5v0__arb4_rr.md
GF180MCU_FD_SC_MCU7T5V0__ARB4_RR -- requirements
Module: gf180mcu_fd_sc_mcu7t5v0__arb4_rr

Interface
REQ-001 Parameter TIMEOUT, default 8, maximum number of GRANT cycles per ownership (legal range 2..255).
REQ-002 CLK  input  1  rising-edge clock for all state.
REQ-003 RN  input  1  reset; one clock, asynchronous, active-low.
REQ-004 REQ  input  4  request per requester, level; bit i = requester i.
REQ-005 DONE  input  1  release strobe from the current owner; ignored while no grant is active.
REQ-006 GNT  output  4  registered one-hot grant, or all-zero.
REQ-007 BUSY  output  1  registered; high whenever GNT is non-zero.
REQ-008 TO  output  1  registered one-cycle pulse marking a forced (timeout) release.
REQ-009 VDD, VSS  inout  1  supply pins; present only when USE_POWER_PINS is defined, with no functional effect.

Function
REQ-010 The state machine SHALL have three states: IDLE, GRANT and RELEASE.
REQ-011 The block SHALL hold a 2-bit priority pointer PTR, a 2-bit owner index OWN and an 8-bit hold counter CNT.
REQ-012 IDLE, REQ == 0: remain in IDLE with GNT = 0.
REQ-013 IDLE, REQ != 0: at the next edge, select the first set bit scanning PTR, PTR+1, PTR+2, PTR+3 (mod 4); load OWN; set GNT[OWN]; clear CNT; enter GRANT.
REQ-014 Grant latency: GNT is visible one cycle after REQ is sampled high in IDLE.
REQ-015 GRANT: CNT SHALL increment by 1 each cycle and SHALL NOT wrap.
REQ-016 GRANT, release condition: DONE == 1 or REQ[OWN] == 0.
REQ-017 On a release condition, at the next edge: GNT = 0; PTR = OWN+1 (mod 4); enter RELEASE.
REQ-018 GRANT, CNT == TIMEOUT-1 without a release condition, at the next edge: GNT = 0; PTR = OWN+1 (mod 4); TO = 1 for exactly that cycle; enter RELEASE.
REQ-019 A release condition and a timeout on the same cycle SHALL count as a normal release, with TO = 0.
REQ-020 RELEASE SHALL last exactly one cycle with GNT = 0 (bus turnaround), then enter IDLE.
REQ-021 Consequence of REQ-020: back-to-back ownerships are separated by at least two grant-free cycles (RELEASE, then IDLE).
REQ-022 Changes to REQ bits other than REQ[OWN] during GRANT or RELEASE SHALL have no effect until IDLE.
REQ-023 GNT SHALL never have more than one bit set, and SHALL never be set in IDLE or RELEASE.
REQ-024 BUSY SHALL equal the OR of GNT in every cycle.
REQ-025 DONE in IDLE or RELEASE SHALL be ignored.
REQ-026 All outputs SHALL be driven directly from flops (no combinational input-to-output path).

Reset
REQ-027 RN low SHALL immediately, without a clock edge, force: state = IDLE; GNT = 0; BUSY = 0; TO = 0; PTR = 0; OWN = 0; CNT = 0.
REQ-028 Reset asserted mid-GRANT SHALL drop GNT asynchronously; no TO pulse or RELEASE cycle SHALL follow.
REQ-029 Reset deassertion is synchronized externally; the first arbitration SHALL occur at the first rising edge with RN high.

Verification
REQ-030 Reset, then REQ = 4'b1111 held with DONE pulsed once per grant -> GNT order 0001, 0010, 0100, 1000, 0001; two zero cycles between grants.
REQ-031 PTR = 2 (after requester 1 was served), then REQ = 4'b0011 -> GNT = 0001 (wrap-around scan).
REQ-032 TIMEOUT = 8, REQ = 4'b0100 held, DONE = 0 -> GNT = 0100 for exactly 8 cycles, then TO = 1 for one cycle with GNT = 0.
REQ-033 DONE = 1 in the same cycle CNT == TIMEOUT-1 -> normal release with TO = 0.
REQ-034 RN pulsed low while GNT = 1000 -> GNT = 0 and BUSY = 0 without a clock edge; next grant for REQ = 4'b1000 is 1000, scanned from PTR = 0.
REQ-035 REQ[OWN] dropped while DONE = 0 -> GNT = 0 at the next edge; DONE pulses while idle -> no state change.
